// File: rtl/ibus_arbiter_if.sv
// Internal-bus request channel: one master issues accesses, one slave returns
// read data and a busy/back-pressure indication.
interface ibus_arbiter_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  be;
  logic        we;
  logic        req;
  logic        lock;
  logic        busy;

  modport master (
    output addr, wdata, be, we, req, lock,
    input  rdata, busy
  );

  modport slave (
    input  addr, wdata, be, we, req, lock,
    output rdata, busy
  );
endinterface

// File: rtl/ibus_arbiter.sv
// Two-master (CPU/DMAC) arbiter in front of the bus state controller: merges both
// requests onto one IBUS port, honouring back-pressure, bus lock and a fairness limit.
//
// Handshake: a master holds req (and its address/data) until it sees busy=0 on a
// ce_r slot; that slot is the accepted access. The owner sees busy = IBUS busy, the
// other master sees busy = its own req, so it stalls for as long as it is locked out.
module ibus_arbiter #(
  parameter int PRIO     = 0,
  parameter int HOLD_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_r,
  ibus_arbiter_if.slave         cpu,
  ibus_arbiter_if.slave         dma,
  ibus_arbiter_if.master        ibus,
  output logic [1:0]            owner,
  output logic                  last,
  output logic [3:0]            hold_cnt
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DMA  = 2'b10
  } owner_e;

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  owner_e     state_q, state_d;
  logic       last_q, last_d;     // 0: CPU was granted last, 1: DMA
  logic [3:0] hold_q, hold_d;

  logic own_req;
  logic own_lock;
  logic other_req;
  logic force_sw;
  logic arb;
  logic cpu_wins_tie;

  always_comb begin
    own_req   = 1'b0;
    own_lock  = 1'b0;
    other_req = 1'b0;
    case (state_q)
      OWN_CPU: begin
        own_req   = cpu.req;
        own_lock  = cpu.lock;
        other_req = dma.req;
      end
      OWN_DMA: begin
        own_req   = dma.req;
        own_lock  = dma.lock;
        other_req = cpu.req;
      end
      default: ;
    endcase
  end

  // Fairness preemption only applies to an unlocked owner with a waiting rival.
  assign force_sw = (state_q != OWN_NONE) && !own_lock && other_req &&
                    (hold_q == HOLD_LIM);

  assign arb = ce_r && !ibus.busy &&
               ((state_q == OWN_NONE) || (!own_req && !own_lock) || force_sw);

  always_comb begin
    cpu_wins_tie = 1'b1;
    if (PRIO == 1) begin
      cpu_wins_tie = 1'b0;
    end else if (PRIO == 2) begin
      cpu_wins_tie = last_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OWN_NONE;
      last_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;

    if (arb) begin
      if (force_sw) begin
        state_d = (state_q == OWN_CPU) ? OWN_DMA : OWN_CPU;
      end else if (cpu.req && dma.req) begin
        state_d = cpu_wins_tie ? OWN_CPU : OWN_DMA;
      end else if (cpu.req) begin
        state_d = OWN_CPU;
      end else if (dma.req) begin
        state_d = OWN_DMA;
      end else begin
        state_d = OWN_NONE;
      end
    end

    if (state_d != state_q) begin
      hold_d = '0;
      if (state_d == OWN_CPU) begin
        last_d = 1'b0;
      end else if (state_d == OWN_DMA) begin
        last_d = 1'b1;
      end
    end else if (ce_r) begin
      if ((state_q == OWN_NONE) || !other_req) begin
        hold_d = '0;
      end else if (own_req && !ibus.busy && !own_lock && (hold_q != HOLD_LIM)) begin
        hold_d = hold_q + 4'd1;
      end
    end
  end

  // The request mux follows the registered owner, so a BSC cycle in flight keeps
  // the old owner's lines until the grant actually moves.
  always_comb begin
    ibus.addr  = '0;
    ibus.wdata = '0;
    ibus.be    = '0;
    ibus.we    = 1'b0;
    ibus.req   = 1'b0;
    ibus.lock  = 1'b0;
    case (state_q)
      OWN_CPU: begin
        ibus.addr  = cpu.addr;
        ibus.wdata = cpu.wdata;
        ibus.be    = cpu.be;
        ibus.we    = cpu.we;
        ibus.req   = cpu.req;
        ibus.lock  = cpu.lock;
      end
      OWN_DMA: begin
        ibus.addr  = dma.addr;
        ibus.wdata = dma.wdata;
        ibus.be    = dma.be;
        ibus.we    = dma.we;
        ibus.req   = dma.req;
        ibus.lock  = dma.lock;
      end
      default: ;
    endcase
  end

  always_comb begin
    cpu.busy = (state_q == OWN_CPU) ? ibus.busy : cpu.req;
    dma.busy = (state_q == OWN_DMA) ? ibus.busy : dma.req;
  end

  assign cpu.rdata = ibus.rdata;
  assign dma.rdata = ibus.rdata;

  assign owner    = state_q;
  assign last     = last_q;
  assign hold_cnt = hold_q;

endmodule
